// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and constants for the register-file dumper
package ibex_pkg;

  // Register-file address width; RV32E only uses the lower half of the space.
  localparam int unsigned RF_ADDR_W = 5;

  // Address carried by the trailing checksum beat (outside the RV32E range,
  // and x31 never gets a second beat, so it is unambiguous in practice).
  localparam logic [RF_ADDR_W-1:0] RF_DUMP_CSUM_ADDR = 5'h1F;

  // Dumper sequencing states.
  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_READ  = 2'd1,
    DUMP_DRAIN = 2'd2
  } rf_dump_state_e;

endpackage

// File: rtl/ibex_rf_dump_obuf.sv
// rtl/ibex_rf_dump_obuf.sv - single-entry valid/ready holding register for dump beats
module ibex_rf_dump_obuf
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [RF_ADDR_W-1:0] in_addr_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [RF_ADDR_W-1:0] out_addr_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o
);

  logic                 valid_q;
  logic [RF_ADDR_W-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic                 last_q;

  // A new beat may enter when empty or when the held beat leaves this cycle,
  // which keeps one beat per cycle flowing under continuous ready.
  assign in_ready_o = ~valid_q | out_ready_i;

  // Load on accept, otherwise empty on handshake; payload is frozen while held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      addr_q  <= in_addr_i;
      data_q  <= in_data_i;
      last_q  <= in_last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/ibex_rf_dumper.sv
// rtl/ibex_rf_dumper.sv - register-file dumper top; IBEX_RF_DUMP_CHECKSUM_EN appends an XOR checksum beat
module ibex_rf_dumper
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rf_req_o,
  input  logic                 rf_gnt_i,
  output logic [4:0]           raddr_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [4:0]           dump_addr_o,
  output logic [DataWidth-1:0] dump_data_o,
  output logic                 dump_last_o
);

  localparam int unsigned          NumWords = 2 ** (RV32E ? 4 : 5);
  localparam logic [RF_ADDR_W-1:0] LastAddr = 5'(NumWords - 1);

  rf_dump_state_e       state_q, state_d;
  logic [RF_ADDR_W-1:0] addr_q, addr_d;
  logic                 done_q, done_d;

  logic                 ld_valid, ld_ready, ld_last;
  logic [RF_ADDR_W-1:0] ld_addr;
  logic [DataWidth-1:0] ld_data;
  logic                 buf_valid, buf_last;
  logic [RF_ADDR_W-1:0] buf_addr;
  logic [DataWidth-1:0] buf_data;
  logic                 last_hs;

`ifdef IBEX_RF_DUMP_CHECKSUM_EN
  logic [DataWidth-1:0] csum_q, csum_d;
  logic                 csum_pend_q, csum_pend_d;
`endif

  // The dump ends when the beat flagged last is taken by the consumer.
  assign last_hs = buf_valid & dump_ready_i & buf_last;

  // Sequencing: start, capture granted reads, then drain the final beat(s).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = addr_q;
    ld_data  = rdata_i;
    ld_last  = 1'b0;
`ifdef IBEX_RF_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
    csum_pend_d = csum_pend_q;
`endif
    case (state_q)
      DUMP_IDLE: begin
        addr_d = '0;
        if (start_i) begin
          state_d = DUMP_READ;
`ifdef IBEX_RF_DUMP_CHECKSUM_EN
          csum_d      = '0;
          csum_pend_d = 1'b0;
`endif
        end
      end
      DUMP_READ: begin
        // A stolen read port or a full, stalled buffer simply holds the counter.
        if (rf_gnt_i && ld_ready) begin
          ld_valid = 1'b1;
`ifdef IBEX_RF_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ rdata_i;
`endif
          if (addr_q == LastAddr) begin
            state_d = DUMP_DRAIN;
`ifdef IBEX_RF_DUMP_CHECKSUM_EN
            csum_pend_d = 1'b1;
`else
            ld_last = 1'b1;
`endif
          end else begin
            addr_d = addr_q + 5'd1;
          end
        end
      end
      DUMP_DRAIN: begin
        if (last_hs) begin
          state_d = DUMP_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end
`ifdef IBEX_RF_DUMP_CHECKSUM_EN
        else if (csum_pend_q && ld_ready) begin
          ld_valid    = 1'b1;
          ld_addr     = RF_DUMP_CSUM_ADDR;
          ld_data     = csum_q;
          ld_last     = 1'b1;
          csum_pend_d = 1'b0;
        end
`endif
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  // Sequencer state, read address counter and completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DUMP_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

`ifdef IBEX_RF_DUMP_CHECKSUM_EN
  // Running XOR of every captured register and the pending-checksum flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q      <= '0;
      csum_pend_q <= 1'b0;
    end else begin
      csum_q      <= csum_d;
      csum_pend_q <= csum_pend_d;
    end
  end
`endif

  ibex_rf_dump_obuf #(
    .DataWidth(DataWidth)
  ) u_obuf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (ld_valid),
    .in_ready_o (ld_ready),
    .in_addr_i  (ld_addr),
    .in_data_i  (ld_data),
    .in_last_i  (ld_last),
    .out_valid_o(buf_valid),
    .out_ready_i(dump_ready_i),
    .out_addr_o (buf_addr),
    .out_data_o (buf_data),
    .out_last_o (buf_last)
  );

  assign busy_o       = (state_q != DUMP_IDLE);
  assign done_o       = done_q;
  assign rf_req_o     = (state_q == DUMP_READ);
  assign raddr_o      = rf_req_o ? addr_q : '0;
  assign dump_valid_o = buf_valid;
  assign dump_addr_o  = buf_addr;
  assign dump_data_o  = buf_data;
  assign dump_last_o  = buf_last;

endmodule
